// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-port arbiter in front of a shared combinational ALU.
//                One operation is in flight at a time (IDLE -> EXEC -> RESP).
//                The result and Zero flag are registered and held until the
//                owning requester consumes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;

  logic        grant_any;
  logic        grant_port;
  logic        accept;
  logic        rsp_release;

  // Grant selection: only the valid flags and the last winner matter, never the payload
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_port = ((PRIO_FIXED == 0) && req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
    // Ready is held off while reset is asserted, even though the state already reads IDLE
    accept     = reset && (state_q == ST_IDLE) && grant_any;
    req0_ready = accept & ~grant_port;
    req1_ready = accept &  grant_port;
  end

  // Next-state and datapath register updates for the three-phase transaction
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp_release  = owner_q ? rsp1_ready : rsp0_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_EXEC;
          owner_d      = grant_port;
          last_grant_d = grant_port;
          opa_d        = grant_port ? req1_a  : req0_a;
          opb_d        = grant_port ? req1_b  : req0_b;
          op_d         = grant_port ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_release) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any transaction and favours port 0 next
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      op_q         <= 3'd0;
      result_q     <= 32'd0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  // Response and ALU drive come straight from registered state
  always_comb begin
    rsp0_valid = reset && (state_q == ST_RESP) && !owner_q;
    rsp1_valid = reset && (state_q == ST_RESP) &&  owner_q;
    rsp_result = result_q;
    rsp_zero   = zero_q;
    alu_a      = opa_q;
    alu_b      = opb_q;
    alu_ctrl   = op_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter (round-robin and fixed
//                priority instances sharing one stimulus set).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_ready, rsp1_ready;

  // round-robin instance
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, alu_zero;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  // fixed-priority instance
  logic        req0_ready_f, req1_ready_f, rsp0_valid_f, rsp1_valid_f, rsp_zero_f, alu_zero_f;
  logic [31:0] rsp_result_f, alu_a_f, alu_b_f, alu_result_f;
  logic [2:0]  alu_ctrl_f;

  int n_checks = 0;
  int n_errors = 0;

  // Reference ALU: returns {zero, result}
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a + b;
      3'd3: r = a ^ b;
      3'd6: r = a - b;
      3'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = ~(a | b);
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result}     = alu_f(alu_ctrl, alu_a, alu_b);
  assign {alu_zero_f, alu_result_f} = alu_f(alu_ctrl_f, alu_a_f, alu_b_f);

  alu_arbiter #(.PRIO_FIXED(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready_f), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready_f), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid_f), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid_f), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result_f), .rsp_zero(rsp_zero_f),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_ctrl(alu_ctrl_f), .alu_result(alu_result_f), .alu_zero(alu_zero_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload(input int p);
    logic [31:0] a;
    a = $urandom;
    if (p == 0) begin
      req0_a  = a;
      req0_b  = (($urandom % 4) == 0) ? a : $urandom;
      req0_op = 3'($urandom_range(7));
    end else begin
      req1_a  = a;
      req1_b  = (($urandom % 4) == 0) ? a : $urandom;
      req1_op = 3'($urandom_range(7));
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 32'h1234; req0_b = 32'h1; req0_op = 3'd2;
    req1_a = 32'h5678; req1_b = 32'h2; req1_op = 3'd2;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_handshake: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
      n_errors++; $display("FAIL reset_alu_drive: got %h %h %h expected zeros", alu_a, alu_b, alu_ctrl);
    end
    n_checks++;
    if ({rsp_zero, rsp_result} !== 33'd0) begin
      n_errors++; $display("FAIL reset_rsp: got zero=%b result=%h expected 0/0", rsp_zero, rsp_result);
    end
    n_checks++;
    if ({req0_ready_f, req1_ready_f, rsp0_valid_f, rsp1_valid_f} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_handshake_fixed: got %b expected 0000", {req0_ready_f, req1_ready_f, rsp0_valid_f, rsp1_valid_f});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_release_idle: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    tick();
  endtask

  task automatic test_single_op();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'd2;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++; $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req0_a = 32'hdead_beef; req0_b = 32'h0; req0_op = 3'd5;
    @(negedge clk);
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid} !== {32'd5, 32'd3, 3'd2, 2'b00}) begin
      n_errors++; $display("FAIL single_exec: got a=%h b=%h op=%h v=%b%b expected 5 3 2 00", alu_a, alu_b, alu_ctrl, rsp0_valid, rsp1_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_result} !== {2'b10, 1'b0, 32'd8}) begin
      n_errors++; $display("FAIL single_resp: got v=%b%b z=%b r=%h expected 10 0 8", rsp0_valid, rsp1_valid, rsp_zero, rsp_result);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      n_errors++; $display("FAIL single_back_idle: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    tick();
  endtask

  task automatic test_zero_flag();
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 3'd6;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_errors++; $display("FAIL zero_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_result} !== {2'b01, 1'b1, 32'd0}) begin
      n_errors++; $display("FAIL zero_resp: got v=%b%b z=%b r=%h expected 01 1 0", rsp0_valid, rsp1_valid, rsp_zero, rsp_result);
    end
    tick();
  endtask

  task automatic test_rr_contention();
    logic [32:0] exp;
    int t;
    apply_reset();
    rand_payload(0); rand_payload(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      t = 0;
      while (!(req0_ready || req1_ready) && t < 8) begin
        tick(); @(negedge clk); t++;
      end
      n_checks++;
      if (t >= 8) begin
        n_errors++; $display("FAIL rr_timeout: got no ready expected grant %0d", k % 2);
      end else if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_errors++; $display("FAIL rr_order: got %b expected port %0d", {req0_ready, req1_ready}, k % 2);
      end
      exp = (k % 2 == 0) ? alu_f(req0_op, req0_a, req0_b) : alu_f(req1_op, req1_a, req1_b);
      tick();
      rand_payload(k % 2);
      tick();
      @(negedge clk);
      n_checks++;
      if ({rsp0_valid, rsp1_valid, rsp_zero, rsp_result} !== {((k % 2 == 0) ? 2'b10 : 2'b01), exp}) begin
        n_errors++; $display("FAIL rr_resp: got v=%b%b z=%b r=%h expected port %0d z=%b r=%h",
                             rsp0_valid, rsp1_valid, rsp_zero, rsp_result, k % 2, exp[32], exp[31:0]);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_fixed_prio();
    logic [32:0] exp;
    apply_reset();
    rand_payload(0); rand_payload(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req0_ready_f, req1_ready_f} !== 2'b10) begin
        n_errors++; $display("FAIL fixed_grant: got %b expected 10", {req0_ready_f, req1_ready_f});
      end
      exp = alu_f(req0_op, req0_a, req0_b);
      tick();
      rand_payload(0);
      @(negedge clk);
      n_checks++;
      if ({req0_ready_f, req1_ready_f} !== 2'b00) begin
        n_errors++; $display("FAIL fixed_exec_ready: got %b expected 00", {req0_ready_f, req1_ready_f});
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({req1_ready_f, rsp0_valid_f, rsp1_valid_f, rsp_zero_f, rsp_result_f} !== {3'b010, exp}) begin
        n_errors++; $display("FAIL fixed_resp: got r1=%b v=%b%b z=%b r=%h expected 0 10 z=%b r=%h",
                             req1_ready_f, rsp0_valid_f, rsp1_valid_f, rsp_zero_f, rsp_result_f, exp[32], exp[31:0]);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    apply_reset();
    rand_payload(1);
    req1_valid = 1'b1; rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_errors++; $display("FAIL bp_grant: got %b expected 01", {req0_ready, req1_ready});
    end
    exp = alu_f(req1_op, req1_a, req1_b);
    tick();
    req1_valid = 1'b0; rand_payload(0); req0_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req0_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_result} !== {3'b001, exp}) begin
        n_errors++; $display("FAIL bp_hold: got r0=%b v=%b%b z=%b r=%h expected 0 01 z=%b r=%h",
                             req0_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_result, exp[32], exp[31:0]);
      end
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({req0_ready, rsp0_valid, rsp1_valid} !== 3'b100) begin
      n_errors++; $display("FAIL bp_release: got r0=%b v=%b%b expected 1 00", req0_ready, rsp0_valid, rsp1_valid);
    end
    tick();
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    apply_reset();
    // first op moves last_grant to port 0
    rand_payload(0); req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    // second op is aborted by reset during EXEC
    rand_payload(0); req0_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++; $display("FAIL rexec_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      n_errors++; $display("FAIL rexec_during: got %b expected 00", {rsp0_valid, rsp1_valid});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
      n_errors++; $display("FAIL rexec_operands: got %h %h %h expected zeros", alu_a, alu_b, alu_ctrl);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
        n_errors++; $display("FAIL rexec_no_rsp: got %b expected 0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
      end
      tick();
      @(negedge clk);
    end
    tick();
    rand_payload(0); rand_payload(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_errors++; $display("FAIL rexec_prio: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Transaction-level scoreboard: one job in flight, result visible two edges after accept
  task automatic test_random();
    int          m_last, m_owner, m_age, g;
    bit          m_busy, e_r0, e_r1, e_v0, e_v1, acc0, acc1;
    logic [32:0] m_exp;
    apply_reset();
    m_last = 1; m_busy = 1'b0; m_owner = 0; m_age = 0; m_exp = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) g = 1 - m_last;
        else g = req1_valid ? 1 : 0;
        e_r0 = (g == 0); e_r1 = (g == 1);
      end
      e_v0 = m_busy && (m_age >= 2) && (m_owner == 0);
      e_v1 = m_busy && (m_age >= 2) && (m_owner == 1);
      n_checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== {e_r0, e_r1, e_v0, e_v1}) begin
        n_errors++; $display("FAIL rand_ctrl cyc %0d: got %b expected %b", cyc,
                             {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, {e_r0, e_r1, e_v0, e_v1});
      end
      if (m_busy && m_age >= 2) begin
        n_checks++;
        if ({rsp_zero, rsp_result} !== m_exp) begin
          n_errors++; $display("FAIL rand_result cyc %0d: got z=%b r=%h expected z=%b r=%h", cyc,
                               rsp_zero, rsp_result, m_exp[32], m_exp[31:0]);
        end
      end
      acc0 = e_r0 && req0_valid;
      acc1 = e_r1 && req1_valid;
      if (acc0 || acc1) begin
        m_busy  = 1'b1;
        m_owner = acc1 ? 1 : 0;
        m_age   = 1;
        m_exp   = acc1 ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
        m_last  = m_owner;
      end else if (m_busy) begin
        if (m_age >= 2 && ((m_owner == 1) ? rsp1_ready : rsp0_ready)) m_busy = 1'b0;
        else m_age = 2;
      end
      tick();
      if (acc0 || !req0_valid) begin
        req0_valid = (($urandom % 3) != 0);
        rand_payload(0);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = (($urandom % 3) != 0);
        rand_payload(1);
      end
      rsp0_ready = (($urandom % 3) != 0);
      rsp1_ready = (($urandom % 3) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    test_reset();
    test_single_op();
    test_zero_flag();
    test_rr_contention();
    test_fixed_prio();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
